// File: rtl/pipe_issue_stage.sv
// Issue stage: FIFO-buffered 22-bit instruction words, decoded and issued one per cycle.
// Without forwarding downstream, the head waits (bubbles) while it reads an rd still in the HAZ_WIN window.
module pipe_issue_stage #(
  parameter int DEPTH   = 4,
  parameter int HAZ_WIN = 2,
  parameter int CNT_W   = 16
) (
  input  logic             clk1,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [21:0]      instr,
  input  logic             stall_in,
  output logic             issue_valid,
  output logic [3:0]       rs1,
  output logic [3:0]       rs2,
  output logic [3:0]       rd,
  output logic [1:0]       func,
  output logic [7:0]       addr,
  output logic [CNT_W-1:0] issued_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);

  typedef struct packed {
    logic [1:0] func;
    logic [3:0] rd;
    logic [3:0] rs1;
    logic [3:0] rs2;
    logic [7:0] addr;
  } instr_t;

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  instr_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic [HAZ_WIN-1:0] sb_v;
  logic [3:0]       sb_rd [HAZ_WIN];

  instr_t head;
  logic   empty;
  logic   hazard;
  logic   push;
  logic   pop;

  assign head     = mem[rd_ptr];
  assign empty    = (count == '0);
  assign in_ready = (count != FULL_CNT);
  assign push     = in_valid && in_ready;
  assign pop      = !stall_in && !empty && !hazard;

  // Register 0 is tracked like any other; rs1==rs2 needs no special case.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < HAZ_WIN; i++) begin
      if (sb_v[i] && (sb_rd[i] == head.rs1 || sb_rd[i] == head.rs2)) begin
        hazard = 1'b1;
      end
    end
    if (empty) begin
      hazard = 1'b0;
    end
  end

  always_ff @(posedge clk1) begin
    if (push && !rst) begin
      mem[wr_ptr] <= instr_t'(instr);
    end
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      issue_valid <= 1'b0;
      rs1         <= '0;
      rs2         <= '0;
      rd          <= '0;
      func        <= '0;
      addr        <= '0;
      issued_cnt  <= '0;
      bubble_cnt  <= '0;
      sb_v        <= '0;
      for (int i = 0; i < HAZ_WIN; i++) begin
        sb_rd[i] <= '0;
      end
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + (PTR_W+1)'(1);
      end else if (!push && pop) begin
        count <= count - (PTR_W+1)'(1);
      end

      if (!stall_in) begin
        issue_valid <= pop;
        if (pop) begin
          rs1        <= head.rs1;
          rs2        <= head.rs2;
          rd         <= head.rd;
          func       <= head.func;
          addr       <= head.addr;
          issued_cnt <= issued_cnt + CNT_W'(1);
        end else if (!empty) begin
          bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
        // Slot 0 mirrors the next output register state; a bubble enters as invalid.
        sb_v[0]  <= pop;
        sb_rd[0] <= pop ? head.rd : rd;
        for (int i = 1; i < HAZ_WIN; i++) begin
          sb_v[i]  <= sb_v[i-1];
          sb_rd[i] <= sb_rd[i-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_issue_stage.sv
// Directed scenarios plus randomized traffic, checked against a queue-based model of the issue stage.
module tb_pipe_issue_stage;

  localparam int DEPTH   = 4;
  localparam int HAZ_WIN = 2;
  localparam int CNT_W   = 16;

  logic             clk1 = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [21:0]      instr = '0;
  logic             stall_in = 1'b0;
  logic             issue_valid;
  logic [3:0]       rs1, rs2, rd;
  logic [1:0]       func;
  logic [7:0]       addr;
  logic [CNT_W-1:0] issued_cnt, bubble_cnt;

  pipe_issue_stage #(.DEPTH(DEPTH), .HAZ_WIN(HAZ_WIN), .CNT_W(CNT_W)) dut (
    .clk1(clk1), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .stall_in(stall_in), .issue_valid(issue_valid), .rs1(rs1), .rs2(rs2), .rd(rd),
    .func(func), .addr(addr), .issued_cnt(issued_cnt), .bubble_cnt(bubble_cnt)
  );

  always #5 clk1 = ~clk1;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: pending words, recent issue history (newest first), expected outputs.
  logic [21:0]      q[$];
  logic [4:0]       hist[$];
  logic             e_v;
  logic [21:0]      e_w;
  logic [CNT_W-1:0] e_iss, e_bub;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  task automatic chk_outputs();
    chk("issue_valid", 32'(issue_valid), 32'(e_v));
    chk("rs1", 32'(rs1), 32'(e_w[15:12]));
    chk("rs2", 32'(rs2), 32'(e_w[11:8]));
    chk("rd", 32'(rd), 32'(e_w[19:16]));
    chk("func", 32'(func), 32'(e_w[21:20]));
    chk("addr", 32'(addr), 32'(e_w[7:0]));
    chk("issued_cnt", 32'(issued_cnt), 32'(e_iss));
    chk("bubble_cnt", 32'(bubble_cnt), 32'(e_bub));
  endtask

  task automatic do_reset();
    @(negedge clk1);
    rst = 1'b1;
    in_valid = 1'b0;
    stall_in = $urandom_range(0, 1) == 1;
    @(posedge clk1);
    #1;
    rst = 1'b0;
    q.delete();
    hist.delete();
    for (int i = 0; i < HAZ_WIN; i++) hist.push_back(5'd0);
    e_v = 1'b0;
    e_w = '0;
    e_iss = '0;
    e_bub = '0;
    chk_outputs();
    chk("in_ready_after_reset", 32'(in_ready), 32'd1);
  endtask

  // One clock: drive inputs, predict the edge, then compare.
  task automatic step(input logic v, input logic [21:0] w, input logic st);
    logic        accept, haz;
    logic [21:0] h;
    @(negedge clk1);
    in_valid = v;
    instr    = w;
    stall_in = st;
    chk("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
    accept = v && (q.size() < DEPTH);
    if (!st) begin
      if (q.size() == 0) begin
        e_v = 1'b0;
      end else begin
        h = q[0];
        haz = 1'b0;
        foreach (hist[i])
          if (hist[i][4] && (hist[i][3:0] == h[15:12] || hist[i][3:0] == h[11:8])) haz = 1'b1;
        if (haz) begin
          e_v = 1'b0;
          e_bub++;
        end else begin
          void'(q.pop_front());
          e_v = 1'b1;
          e_w = h;
          e_iss++;
        end
      end
      hist.push_front({e_v, e_w[19:16]});
      void'(hist.pop_back());
    end
    if (accept) q.push_back(w);
    @(posedge clk1);
    #1;
    chk_outputs();
  endtask

  function automatic logic [21:0] mk(input int f, input int d, input int s1, input int s2, input int a);
    return {2'(f), 4'(d), 4'(s1), 4'(s2), 8'(a)};
  endfunction

  initial begin
    logic [21:0] w;

    // Single word: one-cycle latency after acceptance.
    do_reset();
    step(1'b1, 22'h01537D, 1'b0);
    step(1'b0, 22'h0, 1'b0);
    chk("first_issue_valid", 32'(issue_valid), 32'd1);
    chk("first_rs1", 32'(rs1), 32'd5);
    chk("first_addr", 32'(addr), 32'd125);
    chk("first_issued_cnt", 32'(issued_cnt), 32'd1);

    // Five independent words back to back.
    do_reset();
    for (int i = 1; i <= 5; i++) step(1'b1, mk(0, i, 4 + i, 2 + i, 124 + i), 1'b0);
    step(1'b0, 22'h0, 1'b0);
    chk("stream_issued", 32'(issued_cnt), 32'd5);
    chk("stream_bubbles", 32'(bubble_cnt), 32'd0);

    // Third word reads rd2 right behind its producer: HAZ_WIN bubbles.
    do_reset();
    step(1'b1, 22'h01537D, 1'b0);
    step(1'b1, 22'h126F7E, 1'b0);
    step(1'b1, 22'h131210, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 22'h0, 1'b0);
    chk("haz_bubbles", 32'(bubble_cnt), 32'd2);
    chk("haz_issued", 32'(issued_cnt), 32'd3);

    // Fill while stalled; the fifth word waits for space.
    do_reset();
    for (int i = 1; i <= 5; i++) step(1'b1, mk(1, i, 8 + i, 8 + i, i), 1'b1);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    step(1'b1, mk(1, 5, 13, 13, 5), 1'b1);
    step(1'b1, mk(1, 5, 13, 13, 5), 1'b0);
    step(1'b1, mk(1, 5, 13, 13, 5), 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 22'h0, 1'b0);
    chk("full_issued", 32'(issued_cnt), 32'd5);

    // Stall in the middle of a hazard bubble.
    do_reset();
    step(1'b1, mk(0, 1, 7, 7, 1), 1'b0);
    step(1'b1, mk(0, 2, 1, 9, 2), 1'b0);
    step(1'b0, 22'h0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 22'h0, 1'b1);
    chk("stall_bubble_hold", 32'(bubble_cnt), 32'd1);
    step(1'b0, 22'h0, 1'b0);
    step(1'b0, 22'h0, 1'b0);
    chk("stall_bubbles", 32'(bubble_cnt), 32'd2);
    chk("stall_issue", 32'(issue_valid), 32'd1);

    // Reset with words buffered and rd5 in flight; nothing stale survives.
    do_reset();
    step(1'b1, mk(2, 5, 0, 0, 3), 1'b0);
    step(1'b0, 22'h0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, mk(3, 6, 5, 5, i), 1'b1);
    do_reset();
    step(1'b1, mk(1, 4, 5, 5, 200), 1'b0);
    step(1'b0, 22'h0, 1'b0);
    chk("post_reset_issue", 32'(issue_valid), 32'd1);
    chk("post_reset_rs1", 32'(rs1), 32'd5);

    // Randomized traffic with a narrow register range to provoke hazards.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        w = {2'($urandom), 4'($urandom_range(0, 5)), 4'($urandom_range(0, 5)),
             4'($urandom_range(0, 5)), 8'($urandom)};
        step($urandom_range(0, 2) != 0, w, $urandom_range(0, 3) == 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pipe_issue_stage.md
Name: pipe_issue_stage

Overview:
- Issue/decode stage directly upstream of the 3-stage register-ALU-memory pipeline.
- Accepts packed 22-bit instruction words over a valid/ready handshake and buffers them in a small FIFO.
- Decodes each word into the pipeline's rs1/rs2/rd/func/addr fields.
- Blocks read-after-write hazards, because the pipeline has no forwarding. When the head instruction reads a register still in flight, the stage inserts bubbles (issue_valid=0) instead of issuing it.

Parameters:
- DEPTH, 4, instruction FIFO entries (power of 2, >=2)
- HAZ_WIN, 2, number of previously issued slots whose rd blocks a dependent read
- CNT_W, 16, width of the performance counters

Ports:
- clk1  input  1  single clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  instruction word presented
- in_ready  output  1  FIFO can accept; equals !full
- instr  input  22  [21:20] func, [19:16] rd, [15:12] rs1, [11:8] rs2, [7:0] addr
- stall_in  input  1  downstream freeze; stage holds all state
- issue_valid  output  1  registered; fields below carry a real instruction
- rs1  output  4  registered source 1
- rs2  output  4  registered source 2
- rd  output  4  registered destination
- func  output  2  registered ALU function
- addr  output  8  registered memory address
- issued_cnt  output  CNT_W  instructions issued since reset
- bubble_cnt  output  CNT_W  hazard bubbles inserted since reset

Behaviour:
- Reset (rst high at edge):
  - FIFO pointers and count cleared; in_ready=1 in the following cycle.
  - issue_valid=0; rs1=rs2=rd=0; func=0; addr=0.
  - Scoreboard window: all slots invalid.
  - Both counters = 0.
  - Reset mid-operation discards all buffered and in-flight tracking.
- Push: at an edge with in_valid && in_ready && !rst, instr is written at the tail. Push is permitted while stall_in=1.
- Full: in_ready=0, so a word offered while full is not accepted. There is no bypass.
- Simultaneous push and pop when not full: both occur; count unchanged.
- Scoreboard: HAZ_WIN slots of {v, rd}, shifted every non-stalled edge.
  - Slot 0 receives {issue_valid_next, rd_next}.
  - The oldest slot drops out.
- Hazard: FIFO non-empty and any valid slot has rd equal to head.rs1 or head.rs2.
  - All 16 registers are compared, including register 0.
  - rs1==rs2 is compared once.
- Each edge with stall_in=0 takes exactly one of three actions:
  - Empty: issue_valid<=0, field registers hold; no pop, no counter change.
  - Hazard: issue_valid<=0, fields hold; no pop; bubble_cnt+1.
  - Otherwise: pop head; issue_valid<=1; fields<=decoded head; issued_cnt+1.
- stall_in=1: outputs, scoreboard, FIFO head and counters hold. Pushes still occur.
- Latency: a word accepted at edge E into an empty, hazard-free stage appears on the outputs with issue_valid=1 after edge E+1.
- Back-to-back independent instructions issue one per cycle.
- A dependent instruction immediately behind its producer sees exactly HAZ_WIN bubbles.
- Counters wrap modulo 2^CNT_W.
- FIFO pointers wrap modulo DEPTH.

Test Plan:
- Reset then push 0x01537D (func0 rd1 rs1=5 rs2=3 addr125) at edge E -> after E+1: issue_valid=1, rs1=5, rs2=3, rd=1, func=0, addr=125; issued_cnt=1.
- Stream five independent words (rd1..5, sources 5..9/3..7, addr125..129) on consecutive cycles -> five consecutive issue_valid=1 cycles in order; bubble_cnt=0.
- Push 0x01537D then 0x126F7E (rs1=6, rs2=15, rd=2), then a third word with rs1=1 -> two bubble cycles before the third issues; bubble_cnt=2, issued_cnt=3.
- Hold stall_in=1 and push 5 words with DEPTH=4 -> in_ready falls after 4 accepts, the 5th is held off, outputs frozen. Release stall -> 4 issue in order, then the 5th is accepted and issued.
- Assert stall_in during a hazard bubble -> bubble_cnt does not advance while stalled; hazard resolves only after HAZ_WIN non-stalled edges.
- Assert rst mid-stream with 3 words buffered -> the next cycle shows issue_valid=0, counters 0, in_ready=1. The next pushed word issues with 1-cycle latency and no stale hazard.
